// File: rtl/async_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: Gray read pointer, empty/occupancy, memory read port.
// Define ASYNC_RD_CTRL_FWFT_EN for first-word-fall-through with a two-stage prefetch.
module async_rd_ctrl #(
    parameter  int DEPTH  = 4,
    parameter  int WIDTH  = 8,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [AWIDTH:0]   wr_ptr_rsync,
    output logic [AWIDTH:0]   rd_ptr,
    output logic              mem_rd_en,
    output logic [AWIDTH-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]  mem_rd_data,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_empty,
    output logic [AWIDTH:0]   rd_count
);

    localparam int PW = AWIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rb_q, rb_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wb;
    logic [PW-1:0] count_q, count_d;
    logic          mempty_q;
    logic          rd_valid_q, rd_valid_d;
    logic          pop_mem;

    always_comb begin
        wb   = gray2bin(wr_ptr_rsync);
        rb_d = rb_q + {{AWIDTH{1'b0}}, pop_mem};
    end

`ifdef ASYNC_RD_CTRL_FWFT_EN
    logic             v1_q, v1_d;
    logic             adv;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // s1 is the memory output register (valid v1); s2 is rd_data (valid rd_valid)
    always_comb begin
        adv        = v1_q & (~rd_valid_q | rd_en);
        pop_mem    = ~mempty_q & (~v1_q | adv);
        v1_d       = pop_mem | (v1_q & ~adv);
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (adv) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_rd_data;
        end else if (rd_en & rd_valid_q) begin
            rd_valid_d = 1'b0;
        end
        count_d = wb - rb_d + PW'(v1_d) + PW'(rd_valid_d);
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            v1_q      <= v1_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_empty = ~rd_valid_q;
`else
    always_comb begin
        pop_mem    = rd_en & ~mempty_q;
        rd_valid_d = pop_mem;
        count_d    = wb - rb_d;
    end

    // Memory output is only meaningful the cycle after a read; zero otherwise
    assign rd_data  = rd_valid_q ? mem_rd_data : '0;
    assign rd_empty = mempty_q;
`endif

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rb_q       <= '0;
            rd_ptr_q   <= '0;
            mempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            rb_q       <= rb_d;
            rd_ptr_q   <= bin2gray(rb_d);
            mempty_q   <= (rb_d == wb);
            rd_valid_q <= rd_valid_d;
            count_q    <= count_d;
        end
    end

    assign rd_ptr      = rd_ptr_q;
    assign mem_rd_en   = pop_mem;
    assign mem_rd_addr = rb_q[AWIDTH-1:0];
    assign rd_valid    = rd_valid_q;
    assign rd_count    = count_q;

endmodule

// File: doc/async_rd_ctrl.md
Name: async_rd_ctrl

Overview:
- Read-side controller of the dual-clock FIFO; lives entirely in the rd_clk domain.
- Owns the read pointer, which is kept in Gray code for synchronizing into the write domain. Computes empty and occupancy from the write pointer already synchronized into rd_clk.
- Drives the FIFO memory read port and registers the read data returned by the memory.

Parameters:
- DEPTH, 4: FIFO depth in words; power of two, >= 2. AWIDTH = $clog2(DEPTH).
- WIDTH, 8: data width in bits.

Ports:
- rd_clk  input  1  read-domain clock.
- rst  input  1  synchronous, active-high reset, sampled on rising rd_clk.
- rd_en  input  1  pop request. Standard mode: read strobe. FWFT mode: acknowledge of the current rd_data.
- wr_ptr_rsync  input  AWIDTH+1  write pointer, Gray code, already synchronized into rd_clk.
- rd_ptr  output  AWIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer.
- mem_rd_en  output  1  memory read enable.
- mem_rd_addr  output  AWIDTH  memory read address = rd_ptr binary [AWIDTH-1:0].
- mem_rd_data  input  WIDTH  memory output; registered, valid 1 cycle after mem_rd_en, held while mem_rd_en=0.
- rd_data  output  WIDTH  read data to the user.
- rd_valid  output  1  rd_data holds a valid word.
- rd_empty  output  1  no word is available to pop.
- rd_count  output  AWIDTH+1  registered word count, 0..DEPTH.

Behaviour:
- Reset (synchronous) effects, all taking effect on the next rd_clk edge:
  - rd_ptr=0, rd_empty=1, rd_valid=0, rd_count=0, rd_data=0.
  - All internal valid bits clear; any in-flight memory read is discarded.
  - Reset applies mid-transfer with no special handling; the write side is reset together with this block.
- Pointers:
  - Binary read pointer rb and its Gray image rd_ptr, both AWIDTH+1 bits.
  - Pointers wrap modulo 2*DEPTH; the MSB is the lap bit.
  - Gray encoding is g = b ^ (b>>1). Only registered Gray leaves the block, so exactly one bit changes per increment.
  - wr_ptr_rsync is converted to binary wb combinationally.
- Memory-empty flag (mempty):
  - Registered: mempty <= (rb_next == wb), where rb_next = rb + pop_mem.
  - pop_mem = mem_rd_en.
  - mempty is never cleared by a pop in the same cycle.
  - A write becomes visible only through wr_ptr_rsync, so mempty may read 1 pessimistically. It is never optimistically 0.
- Standard mode (macro undefined):
  - mem_rd_en = rd_en & ~mempty. rd_en while mempty is ignored: no pointer change, no error.
  - rd_valid <= mem_rd_en, i.e. rd_valid is 1 exactly 1 cycle after an accepted read.
  - rd_data = mem_rd_data, registered in the memory, latency 1.
  - rd_empty = mempty.
- Occupancy:
  - rd_count <= wb - (rb + pop_mem), computed in AWIDTH+1-bit modulo arithmetic.
  - Full FIFO reads as DEPTH, i.e. MSB set and low bits 0.
- Wrap-around: after 2*DEPTH pops, rb returns to 0 and rd_ptr to 0; empty detection stays correct across the lap.
- Simultaneous events:
  - wr_ptr_rsync advancing in the same cycle as a pop takes effect in the registered flags one cycle later.
  - The pop and the write are both counted in rd_count.

Optional Feature:
- Macro ASYNC_RD_CTRL_FWFT_EN enables first-word-fall-through with a two-stage prefetch:
  - s1 = memory output register with valid bit v1; s2 = output register rd_data with valid bit rd_valid.
  - adv = v1 & (~rd_valid | rd_en): s2 loads mem_rd_data and rd_valid<=1 when adv.
  - If rd_en & rd_valid & ~adv, then rd_valid<=0.
  - mem_rd_en = ~mempty & (~v1 | adv).
  - v1 <= mem_rd_en | (v1 & ~adv).
  - rd_empty = ~rd_valid. rd_en while ~rd_valid is ignored.
  - Throughput: 1 word/cycle sustained.
  - First-word latency: rd_valid rises 2 cycles after mempty falls.
  - rd_count additionally includes v1 + rd_valid.
- Without the macro: standard mode as described in Behaviour.

Test Plan (DEPTH=4, WIDTH=8):
- Reset: assert rst for 2 cycles with wr_ptr_rsync=0 -> rd_empty=1, rd_valid=0, rd_ptr=0, rd_count=0. A rd_en pulse -> mem_rd_en stays 0 and rd_ptr stays 0.
- Single word, standard mode: wr_ptr_rsync=1, memory word 0xA5 at addr 0, pulse rd_en -> mem_rd_en=1, addr 0; next cycle rd_valid=1, rd_data=0xA5; rd_ptr=1 (Gray 0001); rd_empty=1; rd_count=0.
- Full then drain: wr_ptr_rsync=Gray(4)=0110 -> rd_count=4. Hold rd_en for 4 cycles -> addresses 0,1,2,3; rd_ptr sequence 0001,0011,0010,0110; rd_empty=1 after the fourth pop; a fifth rd_en is ignored.
- Wrap-around: 3 laps of fill 4 / drain 4 -> rd_ptr returns to 0000 after 8 pops; data order is preserved; empty is never falsely 0.
- FWFT (macro defined): wr_ptr_rsync steps 0->3 with data 0x11,0x22,0x33 and rd_en=0 -> rd_valid=1, rd_data=0x11 two cycles after mempty falls, and v1 holds 0x22. Hold rd_en for 3 cycles -> rd_data 0x11,0x22,0x33 on consecutive cycles, then rd_valid=0.
- Reset mid-burst (FWFT): assert rst while v1=1 and rd_valid=1 -> next cycle rd_valid=0, rd_count=0, rd_ptr=0; the stale 0x22 is never presented.
